divisor_frecuencia_multi: RTL and testbench

DIVISOR_FRECUENCIA_MULTI -- requirements
Module: divisor_frecuencia_multi

---
 rtl/divisor_pkg.sv | 13 +
 rtl/divisor_canal.sv | 66 ++++++
 rtl/divisor_frecuencia_multi.sv | 50 +++++
 tb/tb_divisor_frecuencia_multi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared constants and channel-index width helper for the frequency divider
package divisor_pkg;

  localparam int CLK_HZ  = 100_000_000;
  localparam int DIV_1HZ = 50_000_000;
  localparam int DIV_2HZ = 25_000_000;

  // A single-channel build still needs a 1-bit select port
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divisor_canal.sv
// rtl/divisor_canal.sv - one divider channel: shadow/active divisor, counter, tick and square output
// Optional macro DIVISOR_SYNC_EN adds the sync (phase-align) input.
module divisor_canal
  import divisor_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_1HZ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
`ifdef DIVISOR_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             c_out
);

  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_act;
  logic [WIDTH-1:0] cnt;
  logic             running;
  logic             wrap;

  assign running = en && (d_act != '0);
  assign wrap    = (cnt == d_act - WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sh  <= DIV_RESET;
      d_act <= DIV_RESET;
      cnt   <= '0;
      tick  <= 1'b0;
      c_out <= 1'b0;
    end else begin
      if (wr) d_sh <= wr_div;
`ifdef DIVISOR_SYNC_EN
      if (sync) begin
        cnt   <= '0;
        tick  <= 1'b0;
        c_out <= 1'b0;
        d_act <= d_sh;
      end else
`endif
      if (running) begin
        if (wrap) begin
          cnt   <= '0;
          tick  <= 1'b1;
          c_out <= ~c_out;
          // a write landing on the wrap edge takes effect for the very next period
          d_act <= wr ? wr_div : d_sh;
        end else begin
          cnt  <= cnt + WIDTH'(1);
          tick <= 1'b0;
        end
      end else begin
        cnt   <= '0;
        tick  <= 1'b0;
        d_act <= d_sh;
      end
    end
  end

endmodule

// File: rtl/divisor_frecuencia_multi.sv
// rtl/divisor_frecuencia_multi.sv - N_CH independent programmable clock dividers with write decode
// Optional macro DIVISOR_SYNC_EN adds a Sync input that phase-aligns all channels.
module divisor_frecuencia_multi
  import divisor_pkg::*;
#(
  parameter int                N_CH      = 4,
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_1HZ)
) (
  input  logic                    C_100Mhz,
  input  logic                    Reset,
`ifdef DIVISOR_SYNC_EN
  input  logic                    Sync,
`endif
  input  logic [N_CH-1:0]         En,
  input  logic                    Wr,
  input  logic [ch_w(N_CH)-1:0]   Wr_Ch,
  input  logic [WIDTH-1:0]        Wr_Div,
  output logic [N_CH-1:0]         Tick,
  output logic [N_CH-1:0]         C_Out
);

  localparam int CHW = ch_w(N_CH);

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_canal
      // out-of-range channel indices match no instance and are dropped
      logic wr_hit;
      assign wr_hit = Wr && (Wr_Ch == CHW'(i));

      divisor_canal #(
        .WIDTH    (WIDTH),
        .DIV_RESET(DIV_RESET)
      ) u_canal (
        .clk   (C_100Mhz),
        .rst   (Reset),
        .en    (En[i]),
        .wr    (wr_hit),
        .wr_div(Wr_Div),
`ifdef DIVISOR_SYNC_EN
        .sync  (Sync),
`endif
        .tick  (Tick[i]),
        .c_out (C_Out[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// tb/tb_divisor_frecuencia_multi.sv - scoreboard bench for divisor_frecuencia_multi
module tb_divisor_frecuencia_multi;
  import divisor_pkg::*;

  localparam int N_CH = 5;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] DR = 8'd4;
  localparam int CHW = ch_w(N_CH);

  logic C_100Mhz = 1'b0;
  logic Reset = 1'b0;
  logic [N_CH-1:0] En = '0;
  logic Wr = 1'b0;
  logic [CHW-1:0] Wr_Ch = '0;
  logic [WIDTH-1:0] Wr_Div = '0;
`ifdef DIVISOR_SYNC_EN
  logic Sync = 1'b0;
`endif
  logic [N_CH-1:0] Tick;
  logic [N_CH-1:0] C_Out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int              edge_no;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] cout;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference: each channel remembers the edge its current period began on
  int              edge_no = 0;
  int              m_start[N_CH];
  logic [WIDTH-1:0] m_sh[N_CH];
  logic [WIDTH-1:0] m_act[N_CH];
  logic [N_CH-1:0] m_tick = '0;
  logic [N_CH-1:0] m_out = '0;
  logic            sync_now;
  logic            wr_hit;

  divisor_frecuencia_multi #(
    .N_CH(N_CH), .WIDTH(WIDTH), .DIV_RESET(DR)
  ) dut (
    .C_100Mhz(C_100Mhz),
    .Reset   (Reset),
`ifdef DIVISOR_SYNC_EN
    .Sync    (Sync),
`endif
    .En      (En),
    .Wr      (Wr),
    .Wr_Ch   (Wr_Ch),
    .Wr_Div  (Wr_Div),
    .Tick    (Tick),
    .C_Out   (C_Out)
  );

  always #5 C_100Mhz = ~C_100Mhz;

  always @(posedge Reset) begin
    for (int i = 0; i < N_CH; i++) begin
      m_sh[i] = DR; m_act[i] = DR; m_start[i] = edge_no;
    end
    m_tick = '0; m_out = '0;
  end

  always @(posedge C_100Mhz) begin
    edge_no = edge_no + 1;
`ifdef DIVISOR_SYNC_EN
    sync_now = Sync;
`else
    sync_now = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (Reset) begin
        m_sh[i] = DR; m_act[i] = DR; m_start[i] = edge_no;
        m_tick[i] = 1'b0; m_out[i] = 1'b0;
      end else begin
        wr_hit = Wr && (Wr_Ch == CHW'(i));
        if (sync_now) begin
          m_start[i] = edge_no; m_tick[i] = 1'b0; m_out[i] = 1'b0; m_act[i] = m_sh[i];
        end else if (En[i] && m_act[i] != 0) begin
          if (edge_no - m_start[i] == int'(m_act[i])) begin
            m_tick[i] = 1'b1; m_out[i] = ~m_out[i]; m_start[i] = edge_no;
            m_act[i] = wr_hit ? Wr_Div : m_sh[i];
          end else begin
            m_tick[i] = 1'b0;
          end
        end else begin
          m_start[i] = edge_no; m_tick[i] = 1'b0; m_act[i] = m_sh[i];
        end
        if (wr_hit) m_sh[i] = Wr_Div;
      end
    end
    exp_q.push_back('{edge_no, m_tick, m_out});
  end

  always @(negedge C_100Mhz) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (Tick !== mon_e.tick || C_Out !== mon_e.cout) begin
        fails++;
        $display("FAIL sb_edge%0d Tick=%b C_Out=%b expected Tick=%b C_Out=%b",
                 mon_e.edge_no, Tick, C_Out, mon_e.tick, mon_e.cout);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge C_100Mhz);
      #2;
    end
  endtask

  task automatic write(input int ch, input int d);
    Wr = 1'b1; Wr_Ch = CHW'(ch); Wr_Div = WIDTH'(d);
    step(1);
    Wr = 1'b0;
  endtask

  // Called 2 time units after an edge: pulses Reset well clear of both clock edges
  task automatic reset_pulse();
    #4 Reset = 1'b1;
    #1;
    check("rst_async_tick", 32'(Tick), 32'd0);
    check("rst_async_cout", 32'(C_Out), 32'd0);
    #1 Reset = 1'b0;
  endtask

  task automatic wait_phase(input int ch, input int want_left, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (edge_no - m_start[ch] == int'(m_act[ch]) - want_left) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    #1 Reset = 1'b1;
    #1;
    check("reset_tick", 32'(Tick), 32'd0);
    check("reset_cout", 32'(C_Out), 32'd0);
    step(1);
    Reset = 1'b0;
    En = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("ch0_tick_e%0d", k), 32'(Tick[0]), 32'(k % 4 == 0));
      check($sformatf("ch0_cout_e%0d", k), 32'(C_Out[0]), 32'((k / 4) % 2));
    end

    // mid-period write, then write on the wrap edge
    write(1, 3);
    En[1] = 1'b1;
    step(4);
    wait_phase(1, 2, "ch1_find_mid");
    write(1, 5);
    step(12);
    wait_phase(1, 1, "ch1_find_wrap");
    write(1, 5);
    step(12);

    write(2, 1);
    En[2] = 1'b1;
    step(6);
    write(2, 0);
    step(4);
    write(2, 2);
    step(8);

    write(3, 4);
    En[3] = 1'b1;
    step(6);
    En[3] = 1'b0;
    step(3);
    En[3] = 1'b1;
    step(10);

    step(2);
    reset_pulse();
    step(1);
    write(5, 2);
    write(6, 3);
    write(7, 1);
    step(10);

`ifdef DIVISOR_SYNC_EN
    write(0, 3);
    write(1, 5);
    En = '1;
    step(7);
    Sync = 1'b1;
    step(1);
    Sync = 1'b0;
    step(12);
`endif

    for (int n = 0; n < 400; n++) begin
      En = N_CH'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        Wr = 1'b1; Wr_Ch = CHW'($urandom_range(0, 7)); Wr_Div = WIDTH'($urandom_range(0, 6));
      end else begin
        Wr = 1'b0;
      end
`ifdef DIVISOR_SYNC_EN
      Sync = ($urandom_range(0, 29) == 0);
`endif
      if ($urandom_range(0, 49) == 0) reset_pulse();
      step(1);
    end
    Wr = 1'b0;
`ifdef DIVISOR_SYNC_EN
    Sync = 1'b0;
`endif
    step(2);
    @(negedge C_100Mhz);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
